// File: rtl/irq_collector_pkg.sv
// Shared definitions for the irq_collector slice.
//   irq_state_e : states of the irq_o re-trigger machine
//   MaxSrc      : upper limit for NUM_SRC
package irq_collector_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,  // irq_o low, nothing masked pending
        StActive = 2'd1,  // irq_o high
        StGap    = 2'd2   // irq_o forced low for one clock after a drop
    } irq_state_e;

    localparam int unsigned MaxSrc = 32;

endpackage

// File: rtl/irq_collector_edge_detect.sv
// Rising-edge detector for one interrupt source.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   src_i    : raw source level/pulse
//   ev_o     : 1-cycle event on a rising edge of the (optionally synced) source
// A level already high when reset is released does not produce an event: detection
// is held off until the history flop has seen a valid sample of the source.
module irq_collector_edge_detect #(
    parameter bit SYNC_INPUTS = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic src_i,
    output logic ev_o
);

    // Edges needed after reset before the history flop holds a real sample.
    localparam int unsigned PrimeLen = SYNC_INPUTS ? 3 : 1;

    logic                s;
    logic                hist_q;
    logic [PrimeLen-1:0] prime_q;

    if (SYNC_INPUTS) begin : g_sync
        logic [1:0] sync_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], src_i};
            end
        end
        assign s = sync_q[1];
    end else begin : g_nosync
        assign s = src_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            hist_q  <= s;
            prime_q <= (prime_q << 1) | PrimeLen'(1);
        end
    end

    assign ev_o = s & ~hist_q & prime_q[PrimeLen-1];

endmodule

// File: rtl/irq_collector.sv
// Collects timer underflow events into W1C pending bits and drives one level
// interrupt to the PS.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   src_i        : timer interrupt per source (pulse or level, rising edge = event)
//   arm_i        : timer restart pulse per source, drops a stale pending bit
//   mask_i       : 1 = source may assert irq_o
//   clr_valid_i  : strobe applying clr_bits_i
//   clr_bits_i   : write-1-to-clear pattern for pending and overrun
//   pending_o    : latched events, unmasked
//   overrun_o    : sticky, event arrived while already pending
//   irq_o        : registered level interrupt
module irq_collector
    import irq_collector_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter bit          SYNC_INPUTS = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [NUM_SRC-1:0] arm_i,
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic               clr_valid_i,
    input  logic [NUM_SRC-1:0] clr_bits_i,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] overrun_o,
    output logic               irq_o
);

    logic [NUM_SRC-1:0] ev;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_d, pending_q;
    logic [NUM_SRC-1:0] overrun_d, overrun_q;
    logic               any_next;
    logic               keep;
    irq_state_e         state_q;
    logic               irq_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_collector_edge_detect #(
            .SYNC_INPUTS (SYNC_INPUTS)
        ) u_edge (
            .clk     (clk),
            .reset_n (reset_n),
            .src_i   (src_i[i]),
            .ev_o    (ev[i])
        );
    end

    always_comb begin
        clr       = clr_valid_i ? clr_bits_i : '0;
        // Set wins over W1C and arm.
        pending_d = ev | (pending_q & ~(clr | arm_i));
        // Set wins over W1C; arm never touches overrun history.
        overrun_d = (ev & pending_q) | (overrun_q & ~clr);
        any_next  = |(pending_d & mask_i);
        // A masked bit that was pending and stays pending keeps irq_o high. Bits newly
        // latched in the same cycle that the old ones go away do not, so the PS sees
        // a fresh rising edge.
        keep      = |(pending_d & pending_q & mask_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_next) begin
                        state_q <= StActive;
                        irq_q   <= 1'b1;
                    end
                end
                StActive: begin
                    if (!keep) begin
                        state_q <= StGap;
                        irq_q   <= 1'b0;
                    end
                end
                StGap: begin
                    state_q <= any_next ? StActive : StIdle;
                    irq_q   <= any_next;
                end
                default: begin
                    state_q <= StIdle;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    assign irq_o     = irq_q;

endmodule
